// File: rtl/delay_tank_if.sv
// Bus bundle for delay_tank: write-side controls in, observed slot/position out.
// The en signal exists only when DELAY_TANK_STALL_EN is defined.
interface delay_tank_if #(
  parameter int WIDTH  = 1,
  parameter int LENGTH = 576
) ();
  localparam int PW = $clog2(LENGTH);

  logic [WIDTH-1:0] in;
  logic             wr;
  logic             clr;
  logic [WIDTH-1:0] out;
  logic [PW-1:0]    pos;
  logic             sync;
`ifdef DELAY_TANK_STALL_EN
  logic             en;

  modport master (output in, output wr, output clr, output en,
                  input out, input pos, input sync);
  modport slave  (input in, input wr, input clr, input en,
                  output out, output pos, output sync);
`else
  modport master (output in, output wr, output clr,
                  input out, input pos, input sync);
  modport slave  (input in, input wr, input clr,
                  output out, output pos, output sync);
`endif
endinterface

// File: rtl/delay_tank.sv
// Recirculating delay line: WIDTH channels, LENGTH slots per lap, slot counter and sync.
// Optional DELAY_TANK_STALL_EN adds an advance enable (en) that freezes the whole tank.
module delay_tank #(
  parameter int WIDTH  = 1,
  parameter int LENGTH = 576
) (
  input  logic        clk,
  input  logic        rst_n,
  delay_tank_if.slave bus
);
  localparam int PW = $clog2(LENGTH);

  if (LENGTH < 2) begin : g_bad_length
    $error("delay_tank: LENGTH must be at least 2");
  end

  logic             adv;
  logic [WIDTH-1:0] head;
  logic [PW-1:0]    pos;
  // The last element is the registered out, so a slot takes exactly LENGTH advances per lap.
  logic [WIDTH-1:0] tank [LENGTH];

`ifdef DELAY_TANK_STALL_EN
  assign adv = bus.en;
`else
  assign adv = 1'b1;
`endif

  // wr has priority over clr; with neither the emerging slot recirculates.
  always_comb begin
    head = tank[LENGTH-1];
    if (bus.wr)       head = bus.in;
    else if (bus.clr) head = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LENGTH; i++) tank[i] <= '0;
      pos <= '0;
    end else if (adv) begin
      tank[0] <= head;
      for (int i = 1; i < LENGTH; i++) tank[i] <= tank[i-1];
      pos <= (pos == PW'(LENGTH-1)) ? '0 : pos + 1'b1;
    end
  end

  assign bus.out  = tank[LENGTH-1];
  assign bus.pos  = pos;
  assign bus.sync = (pos == '0);
endmodule

// File: tb/tb_delay_tank.sv
// Directed bench for delay_tank: small tank (WIDTH=2, LENGTH=4) and full EDSAC tank (1 x 576).
module tb_delay_tank;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_b = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   syncs;

  always #5 clk = ~clk;

  delay_tank_if #(.WIDTH(2), .LENGTH(4))   t4 ();
  delay_tank_if #(.WIDTH(1), .LENGTH(576)) tb ();

  delay_tank #(.WIDTH(2), .LENGTH(4))   dut4   (.clk(clk), .rst_n(rst_n), .bus(t4));
  delay_tank #(.WIDTH(1), .LENGTH(576)) dut576 (.clk(clk), .rst_n(rst_b), .bus(tb));

`ifdef DELAY_TANK_STALL_EN
  assign tb.en = 1'b1;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic c, input logic [1:0] d);
    t4.wr  = w;
    t4.clr = c;
    t4.in  = d;
  endtask

  initial begin
    drive(1'b0, 1'b0, 2'b00);
    tb.wr = 1'b0; tb.clr = 1'b0; tb.in = 1'b0;
`ifdef DELAY_TANK_STALL_EN
    t4.en = 1'b1;
`endif
    #2;
    check("reset_out",  32'(t4.out),  32'h0);
    check("reset_pos",  32'(t4.pos),  32'h0);
    check("reset_sync", 32'(t4.sync), 32'h1);
    #10 rst_n = 1'b1;
    tick();
    // clock edge after release is the first advance; realign to the edge just seen
    check("first_pos", 32'(t4.pos), 32'h1);
    tick(); tick(); tick();

    // free-run: pos 0,1,2,3,... with sync only at pos 0
    for (int i = 0; i < 12; i++) begin
      check("run_pos",  32'(t4.pos),  32'(i % 4));
      check("run_sync", 32'(t4.sync), (i % 4 == 0) ? 32'h1 : 32'h0);
      tick();
    end

    // single write at pos 1, observed every lap
    tick();
    check("wr_at_pos1", 32'(t4.pos), 32'h1);
    drive(1'b1, 1'b0, 2'b10);
    tick();
    drive(1'b0, 1'b0, 2'b00);
    for (int j = 0; j < 8; j++) begin
      check("lap_out", 32'(t4.out), (((2 + j) % 4) == 1) ? 32'h2 : 32'h0);
      tick();
    end

    // asynchronous reset mid-stream
    rst_n = 1'b0;
    #2;
    check("mid_rst_out",  32'(t4.out),  32'h0);
    check("mid_rst_pos",  32'(t4.pos),  32'h0);
    check("mid_rst_sync", 32'(t4.sync), 32'h1);
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check("post_rst_out", 32'(t4.out), 32'h0);
      check("post_rst_pos", 32'(t4.pos), 32'(j % 4));
      tick();
    end

    // load 01,10,11,01 into slots 0..3
    drive(1'b1, 1'b0, 2'b01); tick();
    drive(1'b1, 1'b0, 2'b10); tick();
    drive(1'b1, 1'b0, 2'b11); tick();
    drive(1'b1, 1'b0, 2'b01); tick();
    drive(1'b0, 1'b0, 2'b00);
    check("ld_s0", 32'(t4.out), 32'h1); tick();
    check("ld_s1", 32'(t4.out), 32'h2); tick();
    check("ld_s2", 32'(t4.out), 32'h3);
    drive(1'b1, 1'b1, 2'b00); tick();
    drive(1'b0, 1'b0, 2'b00);
    check("ld_s3", 32'(t4.out), 32'h1); tick();
    // wr+clr at slot 2 wrote in=00
    check("wc_s0", 32'(t4.out), 32'h1);
    drive(1'b0, 1'b1, 2'b11); tick();
    drive(1'b0, 1'b0, 2'b00);
    check("wc_s1", 32'(t4.out), 32'h2); tick();
    check("wc_s2", 32'(t4.out), 32'h0); tick();
    check("wc_s3", 32'(t4.out), 32'h1); tick();
    // clr alone at slot 0
    check("clr_s0", 32'(t4.out), 32'h0); tick();
    check("clr_s1", 32'(t4.out), 32'h2); tick();
    check("clr_s2", 32'(t4.out), 32'h0); tick();
    check("clr_s3", 32'(t4.out), 32'h1); tick();

`ifdef DELAY_TANK_STALL_EN
    tick(); tick(); tick();
    check("stall_pre_pos", 32'(t4.pos), 32'h3);
    t4.en = 1'b0;
    drive(1'b1, 1'b0, 2'b11);
    for (int j = 0; j < 3; j++) begin
      tick();
      check("stall_out", 32'(t4.out), 32'h1);
      check("stall_pos", 32'(t4.pos), 32'h3);
    end
    t4.en = 1'b1;
    drive(1'b0, 1'b0, 2'b00);
    tick();
    check("resume_s0", 32'(t4.out), 32'h0);
    check("resume_pos", 32'(t4.pos), 32'h0); tick();
    check("resume_s1", 32'(t4.out), 32'h2); tick();
    check("resume_s2", 32'(t4.out), 32'h0); tick();
    check("resume_s3", 32'(t4.out), 32'h1);
`endif

    // full-length tank: write at slot 575, read it one lap later
    rst_b = 1'b1;
    tick();
    check("big_pos1", 32'(tb.pos), 32'h1);
    syncs = 0;
    for (int i = 1; i < 575; i++) begin
      if (tb.sync) syncs++;
      tick();
    end
    check("big_pos575", 32'(tb.pos), 32'd575);
    check("big_out_pre", 32'(tb.out), 32'h0);
    tb.wr = 1'b1; tb.in = 1'b1;
    tick();
    tb.wr = 1'b0; tb.in = 1'b0;
    check("big_wrap_pos",  32'(tb.pos),  32'h0);
    check("big_wrap_sync", 32'(tb.sync), 32'h1);
    for (int i = 0; i < 575; i++) begin
      if (tb.sync) syncs++;
      tick();
    end
    check("big_pos575b", 32'(tb.pos), 32'd575);
    check("big_out_lap", 32'(tb.out), 32'h1);
    check("big_sync_count", 32'(syncs), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
